// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
//   fetch_state_t   : sequencer state encoding
//   FMT_BRANCH      : instr[1:0] value marking a branch-format instruction
//   *_DEFAULT       : default bus widths
//   is_branch()     : format decode helper
package fetch_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 8;
    localparam int unsigned INSTR_W_DEFAULT = 16;

    localparam logic [1:0] FMT_BRANCH = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_COMMIT = 3'd3,
        S_FAULT  = 3'd4
    } fetch_state_t;

    // Branch-format instructions skip the execute phase.
    function automatic logic is_branch(input logic [1:0] fmt);
        return fmt == FMT_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and execution-unit handshake bundle.
//   imem_req/imem_addr  : fetch request and address (sequencer -> memory)
//   imem_ack/imem_data  : instruction word return (memory -> sequencer)
//   exec_start          : execution start pulse (sequencer -> exec unit)
//   exec_done/alu_result: completion and result (exec unit -> sequencer)
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               exec_start;
    logic               exec_done;
    logic [INSTR_W-1:0] alu_result;

    modport master (
        output imem_req,
        output imem_addr,
        output exec_start,
        input  imem_ack,
        input  imem_data,
        input  exec_done,
        input  alu_result
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  exec_start,
        output imem_ack,
        output imem_data,
        output exec_done,
        output alu_result
    );

endinterface

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: saturating count of consecutive no-ack fetch cycles.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the count (held while not fetching)
//   i_count_en     : a fetch cycle without ack
//   o_expired_c    : this counted cycle brings the count to TIMEOUT
//                    (combinational, so the sequencer leaves FETCH on
//                    the same edge the count reaches TIMEOUT)
// TIMEOUT = 0 disables expiry.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired_c
);

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

    logic [CNT_W-1:0] r_count;

    // Saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (TIMEOUT != 0) && i_count_en && (r_count >= CNT_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-unit control FSM: fetch -> (execute) -> commit.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_run              : level, allows new fetches (sampled in IDLE/COMMIT)
//   i_pc_q             : current PC from the pc register
//   bus (master)       : imem req/ack and exec start/done handshakes
//   o_instr            : latched instruction word
//   o_last_alu_result  : latched execution result for branch resolution
//   o_en_pc            : one-cycle PC load pulse per retired instruction
//   o_busy             : in FETCH, EXEC or COMMIT
//   o_fault            : sticky fetch-timeout flag
//   o_retired_count    : wrapping retired-instruction counter
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic [ADDR_W-1:0]     i_pc_q,
    fetch_sequencer_if.master     bus,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [INSTR_W-1:0]    o_last_alu_result,
    output logic                  o_en_pc,
    output logic                  o_busy,
    output logic                  o_fault,
    output logic [15:0]           o_retired_count
);

    localparam int unsigned RETIRED_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
    localparam logic [2:0] ST_FETCH  = 3'(S_FETCH);
    localparam logic [2:0] ST_EXEC   = 3'(S_EXEC);
    localparam logic [2:0] ST_COMMIT = 3'(S_COMMIT);
    localparam logic [2:0] ST_FAULT  = 3'(S_FAULT);

    logic [2:0]           r_state;
    logic                 r_imem_req;
    logic                 r_exec_start;
    logic                 r_en_pc;
    logic                 r_busy;
    logic                 r_fault;
    logic [INSTR_W-1:0]   r_instr;
    logic [INSTR_W-1:0]   r_last_alu;
    logic [RETIRED_W-1:0] r_retired;

    logic [2:0] w_state_nxt;
    logic       w_imem_req_nxt;
    logic       w_exec_start_nxt;
    logic       w_en_pc_nxt;
    logic       w_busy_nxt;
    logic       w_fault_nxt;
    logic       w_instr_load;
    logic       w_result_load;
    logic       w_retire;
    logic       w_wd_clear;
    logic       w_wd_count_en;
    logic       w_wd_expired;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_wd_clear),
        .i_count_en  (w_wd_count_en),
        .o_expired_c (w_wd_expired)
    );

    // Next state and next registered-output values.
    always_comb begin
        w_state_nxt      = r_state;
        w_imem_req_nxt   = 1'b0;
        w_exec_start_nxt = 1'b0;
        w_en_pc_nxt      = 1'b0;
        w_busy_nxt       = 1'b0;
        w_fault_nxt      = 1'b0;
        w_instr_load     = 1'b0;
        w_result_load    = 1'b0;
        w_retire         = 1'b0;
        w_wd_clear       = 1'b1;
        w_wd_count_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_wd_clear    = 1'b0;
                w_wd_count_en = !bus.imem_ack;
                if (bus.imem_ack) begin
                    w_instr_load = 1'b1;
                    w_state_nxt  = is_branch(bus.imem_data[1:0]) ? ST_COMMIT : ST_EXEC;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    w_result_load = 1'b1;
                    w_state_nxt   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_retire    = 1'b1;
                w_state_nxt = i_run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_imem_req_nxt   = (w_state_nxt == ST_FETCH);
        // Only FETCH enters EXEC, so this marks the first EXEC cycle.
        w_exec_start_nxt = (r_state == ST_FETCH) && (w_state_nxt == ST_EXEC);
        w_en_pc_nxt      = (w_state_nxt == ST_COMMIT);
        w_busy_nxt       = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC)
                         || (w_state_nxt == ST_COMMIT);
        w_fault_nxt      = (w_state_nxt == ST_FAULT);
    end

    // State, registered outputs and datapath latches.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_imem_req   <= 1'b0;
            r_exec_start <= 1'b0;
            r_en_pc      <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_instr      <= '0;
            r_last_alu   <= '0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_imem_req   <= w_imem_req_nxt;
            r_exec_start <= w_exec_start_nxt;
            r_en_pc      <= w_en_pc_nxt;
            r_busy       <= w_busy_nxt;
            r_fault      <= w_fault_nxt;
            if (w_instr_load)  r_instr    <= bus.imem_data;
            if (w_result_load) r_last_alu <= bus.alu_result;
            if (w_retire)      r_retired  <= r_retired + RETIRED_W'(1);
        end
    end

    // Address follows pc_q combinationally so a PC loaded at the end of
    // COMMIT is presented in the very next FETCH cycle.
    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_imem_req ? i_pc_q : '0;
    assign bus.exec_start = r_exec_start;

    assign o_instr           = r_instr;
    assign o_last_alu_result = r_last_alu;
    assign o_en_pc           = r_en_pc;
    assign o_busy            = r_busy;
    assign o_fault           = r_fault;
    assign o_retired_count   = r_retired;

endmodule
